// File: rtl/imem_loader.sv
// Instruction-memory loader.
// Collects a big-endian byte stream into 32-bit words and writes them one at a
// time into instruction memory, starting at word 0. The CPU is held in reset
// until a complete image has been written.
module imem_loader #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned MAX_WORDS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   length_words,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [31:0]       imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    localparam logic [ADDR_W:0] LP_MAX = (ADDR_W + 1)'(MAX_WORDS);
    localparam int unsigned     LP_PAD = 32 - ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [1:0]        r_byte_cnt;
    logic [ADDR_W:0]   r_word_cnt;
    logic [ADDR_W:0]   r_len;
    logic              r_we;
    logic [31:0]       r_waddr;
    logic [31:0]       r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_hold;

    state_t            w_state;
    logic [1:0]        w_byte_cnt;
    logic [ADDR_W:0]   w_word_cnt;
    logic [ADDR_W:0]   w_word_inc;
    logic [ADDR_W:0]   w_len;
    logic              w_we;
    logic [31:0]       w_waddr;
    logic [31:0]       w_wdata;
    logic              w_busy;
    logic              w_done;
    logic              w_err;
    logic              w_hold;
    logic              w_ready;
    logic              w_len_bad;

    // s_ready depends only on the state register, never on inputs.
    assign w_ready    = (r_state == S_RECV);
    assign w_len_bad  = (length_words == '0) || (length_words > LP_MAX);
    assign w_word_inc = r_word_cnt + 1'b1;

    assign s_ready    = w_ready;
    assign imem_we    = r_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign cpu_hold   = r_hold;

    // State and registered-output update; reset discards any partial word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_len      <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_hold     <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_byte_cnt <= w_byte_cnt;
            r_word_cnt <= w_word_cnt;
            r_len      <= w_len;
            r_we       <= w_we;
            r_waddr    <= w_waddr;
            r_wdata    <= w_wdata;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
            r_hold     <= w_hold;
        end
    end

    // Next-state and next-output decode; outputs are computed one cycle ahead
    // so that every output except s_ready comes straight from a flop.
    always_comb begin
        w_state    = r_state;
        w_byte_cnt = r_byte_cnt;
        w_word_cnt = r_word_cnt;
        w_len      = r_len;
        w_we       = 1'b0;
        w_waddr    = r_waddr;
        w_wdata    = r_wdata;
        w_busy     = r_busy;
        w_done     = r_done;
        w_err      = r_err;
        w_hold     = r_hold;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (w_len_bad) begin
                        w_state = S_IDLE;
                        w_err   = 1'b1;
                        w_done  = 1'b0;
                        w_busy  = 1'b0;
                        w_hold  = 1'b1;
                    end else begin
                        w_state    = S_RECV;
                        w_len      = length_words;
                        w_err      = 1'b0;
                        w_done     = 1'b0;
                        w_busy     = 1'b1;
                        w_hold     = 1'b1;
                        w_byte_cnt = '0;
                        w_word_cnt = '0;
                    end
                end
            end
            S_RECV: begin
                if (s_valid && w_ready) begin
                    w_wdata    = {r_wdata[23:0], s_data};
                    w_byte_cnt = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_state = S_WRITE;
                        w_we    = 1'b1;
                        w_waddr = {{LP_PAD{1'b0}}, r_word_cnt[ADDR_W-1:0], 2'b00};
                    end
                end
            end
            S_WRITE: begin
                w_word_cnt = w_word_inc;
                if (w_word_inc == r_len) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_hold  = 1'b0;
                end else begin
                    w_state = S_RECV;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

endmodule
